// File: rtl/spi_m.sv
// spi_m: SPI mode-0 master transmitter, MSB first, fed from a valid/ready byte stream.
// Optional MISO receive path is compiled in when SPI_M_MISO_EN is defined.
module spi_m #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_spi_mosi,
  output logic       o_spi_clk,
  output logic       o_spi_nss
`ifdef SPI_M_MISO_EN
  ,
  input  logic       i_spi_miso,
  output logic [7:0] o_rx_data,
  output logic       o_rx_dataValid
`endif
);

  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] DIV_T   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_T = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_T  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_T  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT_LO, S_SHIFT_HI, S_WAIT, S_HOLD, S_GAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_last;
  logic          r_mosi;
  logic          r_sclk;
  logic          r_nss;

  logic w_term;
  logic w_bit_end;
  logic w_accept;

  always_comb begin
    w_term = 1'b0;
    case (r_state)
      S_SETUP:    w_term = (r_cnt == SETUP_T);
      S_SHIFT_LO: w_term = (r_cnt == DIV_T);
      S_SHIFT_HI: w_term = (r_cnt == DIV_T);
      S_HOLD:     w_term = (r_cnt == HOLD_T);
      S_GAP:      w_term = (r_cnt == IDLE_T);
      default:    w_term = 1'b0;
    endcase
  end

  // Back-to-back bytes are offered only on the very last SCLK-high cycle of bit 0,
  // so an accepted byte always starts on the falling edge that follows.
  assign w_bit_end  = (r_state == S_SHIFT_HI) && w_term && (r_bit == 3'd7);
  assign o_tx_ready = !i_reset && ((r_state == S_IDLE) || (r_state == S_WAIT) ||
                                   (w_bit_end && !r_last));
  assign w_accept   = i_tx_valid && o_tx_ready;
  assign o_busy     = (r_state != S_IDLE);
  assign o_spi_mosi = r_mosi;
  assign o_spi_clk  = r_sclk;
  assign o_spi_nss  = r_nss;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_sh    <= 8'd0;
      r_last  <= 1'b0;
      r_mosi  <= 1'b0;
      r_sclk  <= 1'b0;
      r_nss   <= 1'b1;
    end else begin
      r_cnt <= w_term ? '0 : r_cnt + CW'(1);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_sh    <= i_tx_data;
            r_last  <= i_tx_last;
            r_mosi  <= i_tx_data[7];
            r_bit   <= 3'd0;
            r_nss   <= 1'b0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_term) r_state <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          if (w_term) begin
            r_sclk  <= 1'b1;
            r_state <= S_SHIFT_HI;
          end
        end
        S_SHIFT_HI: begin
          if (w_term) begin
            r_sclk <= 1'b0;
            if (r_bit == 3'd7) begin
              if (w_accept) begin
                r_sh    <= i_tx_data;
                r_last  <= i_tx_last;
                r_mosi  <= i_tx_data[7];
                r_bit   <= 3'd0;
                r_state <= S_SHIFT_LO;
              end else if (r_last) begin
                r_state <= S_HOLD;
              end else begin
                r_state <= S_WAIT;
              end
            end else begin
              r_sh    <= {r_sh[6:0], 1'b0};
              r_mosi  <= r_sh[6];
              r_bit   <= r_bit + 3'd1;
              r_state <= S_SHIFT_LO;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_sh    <= i_tx_data;
            r_last  <= i_tx_last;
            r_mosi  <= i_tx_data[7];
            r_bit   <= 3'd0;
            r_state <= S_SHIFT_LO;
          end
        end
        S_HOLD: begin
          if (w_term) begin
            r_nss   <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_term) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_M_MISO_EN
  // With CLK_DIV>=3 the 8th sample lands no later than the final falling edge;
  // at CLK_DIV=2 the sync delay pushes the byte one cycle past it.
  localparam bit EARLY = (CLK_DIV >= 3);

  logic [1:0] r_miso_sync;
  logic [2:0] r_rise_pipe;
  logic [7:0] r_rx_sh;
  logic [2:0] r_rx_cnt;
  logic       w_rise;
  logic       w_samp;
  logic       w_samp8;
  logic       w_emit;
  logic [7:0] w_rx_byte;

  assign w_rise    = (r_state == S_SHIFT_LO) && w_term;
  assign w_samp    = r_rise_pipe[2];
  assign w_samp8   = w_samp && (r_rx_cnt == 3'd7);
  assign w_rx_byte = {r_rx_sh[6:0], r_miso_sync[1]};
  assign w_emit    = EARLY ? w_bit_end : w_samp8;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_miso_sync    <= 2'b00;
      r_rise_pipe    <= 3'b000;
      r_rx_sh        <= 8'd0;
      r_rx_cnt       <= 3'd0;
      o_rx_data      <= 8'd0;
      o_rx_dataValid <= 1'b0;
    end else begin
      r_miso_sync    <= {r_miso_sync[0], i_spi_miso};
      r_rise_pipe    <= {r_rise_pipe[1:0], w_rise};
      o_rx_dataValid <= 1'b0;
      if (w_samp) begin
        r_rx_sh  <= w_rx_byte;
        r_rx_cnt <= r_rx_cnt + 3'd1;
      end
      if (w_emit) begin
        o_rx_dataValid <= 1'b1;
        o_rx_data      <= w_samp8 ? w_rx_byte : r_rx_sh;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_m.sv
// Bench for spi_m: drives bytes through valid/ready, decodes MOSI at each SCLK rise
// and compares the decoded bytes against a queue of expected bytes.
module tb_spi_m;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;
  localparam int BOUND    = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, busy, mosi, sclk, nss;
`ifdef SPI_M_MISO_EN
  logic [7:0] rx_data;
  logic       rx_valid;
  int         rx_pulses = 0;
  logic [7:0] rx_last = 8'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  int cyc = 0, fall_cyc = 0, last_rise = 0, rises = 0, bits = 0, max_gap = 0;
  int low_len = 0, xfer_rises = 0, done_cnt = 0, bytes_seen = 0, abandoned = 0;
  logic [7:0] mon_sh = 8'd0;
  logic prev_nss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

  always #5 clk = ~clk;

  spi_m #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
`ifdef SPI_M_MISO_EN
    .i_spi_miso(mosi),
    .o_rx_data(rx_data),
    .o_rx_dataValid(rx_valid),
`endif
    .i_clk(clk),
    .i_reset(rst),
    .i_tx_data(tx_data),
    .i_tx_valid(tx_valid),
    .i_tx_last(tx_last),
    .o_tx_ready(tx_ready),
    .o_busy(busy),
    .o_spi_mosi(mosi),
    .o_spi_clk(sclk),
    .o_spi_nss(nss)
  );

  // SPI slave model and scoreboard consumer
  always @(negedge clk) begin
    logic [7:0] exp_b;
    cyc++;
    if (prev_nss === 1'b1 && nss === 1'b0) begin
      fall_cyc = cyc; rises = 0; bits = 0; max_gap = 0;
    end
    if (nss === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) begin
      if (rises < 8) begin
        n_checks++;
        if (cyc - fall_cyc != CS_SETUP + CLK_DIV + rises * 2 * CLK_DIV) begin
          n_fail++;
          $display("FAIL rise_timing: rise %0d at %0d cycles after NSS fall, required %0d",
                   rises, cyc - fall_cyc, CS_SETUP + CLK_DIV + rises * 2 * CLK_DIV);
        end
      end
      if (rises > 0 && cyc - last_rise > max_gap) max_gap = cyc - last_rise;
      last_rise = cyc;
      rises++;
      mon_sh = {mon_sh[6:0], mosi};
      bits++;
      if (bits == 8) begin
        bits = 0;
        bytes_seen++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_byte: got unexpected byte 0x%02h, queue empty", mon_sh);
        end else begin
          exp_b = sb.pop_front();
          if (mon_sh !== exp_b) begin
            n_fail++;
            $display("FAIL sb_byte: got 0x%02h, required 0x%02h", mon_sh, exp_b);
          end
        end
      end
    end
    if (prev_sclk === 1'b1 && sclk === 1'b1) begin
      n_checks++;
      if (mosi !== prev_mosi) begin
        n_fail++;
        $display("FAIL mosi_stable: MOSI changed %b->%b while SCLK high", prev_mosi, mosi);
      end
    end
    if (prev_nss === 1'b0 && nss === 1'b1) begin
      low_len = cyc - fall_cyc;
      xfer_rises = rises;
      if (bits != 0) abandoned++;
      bits = 0;
      done_cnt++;
    end
`ifdef SPI_M_MISO_EN
    if (rx_valid === 1'b1) begin
      rx_pulses++;
      rx_last = rx_data;
      n_checks++;
      if (!(prev_sclk === 1'b1 && sclk === 1'b0)) begin
        n_fail++;
        $display("FAIL rx_align: rx_dataValid with sclk %b->%b, required 1->0", prev_sclk, sclk);
      end
    end
`endif
    prev_nss = nss; prev_sclk = sclk; prev_mosi = mosi;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input bit expect_it,
                      output logic sclk_acc);
    int t;
    t = 0;
    sclk_acc = 1'b0;
    tx_data = d; tx_valid = 1'b1; tx_last = last;
    while (tx_ready !== 1'b1 && t < BOUND) begin
      tick();
      t++;
    end
    if (t >= BOUND) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: byte 0x%02h not accepted within %0d cycles", d, BOUND);
      tx_valid = 1'b0;
    end else begin
      sclk_acc = sclk;
      if (expect_it) sb.push_back(d);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data = ~d;
    end
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < BOUND) begin
      tick();
      t++;
    end
    if (t >= BOUND) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: NSS did not rise within %0d cycles", BOUND);
    end
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < BOUND) begin
      tick();
      t++;
    end
    if (t >= BOUND) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: ready did not return within %0d cycles", BOUND);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({nss, sclk, mosi, busy, tx_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_state: nss,sclk,mosi,busy,ready=%b required 10000",
               {nss, sclk, mosi, busy, tx_ready});
    end
`ifdef SPI_M_MISO_EN
    n_checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_rx: valid=%b data=0x%02h required 0/0x00", rx_valid, rx_data);
    end
`endif
    rst = 1'b0;
    #1;
    n_checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b busy=%b required 1/0", tx_ready, busy);
    end
  endtask

  task automatic test_single;
    int d0, g;
    logic s;
    d0 = done_cnt;
    send(8'hA5, 1'b1, 1'b1, s);
    wait_done(d0);
    n_checks++;
    if (low_len != CS_SETUP + 16 * CLK_DIV + CS_HOLD) begin
      n_fail++;
      $display("FAIL single_nss_low: %0d cycles, required %0d", low_len,
               CS_SETUP + 16 * CLK_DIV + CS_HOLD);
    end
    n_checks++;
    if (xfer_rises != 8) begin
      n_fail++;
      $display("FAIL single_rises: %0d, required 8", xfer_rises);
    end
    n_checks++;
    if ({busy, tx_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL gap_state: busy,ready=%b required 10", {busy, tx_ready});
    end
    g = 0;
    while (tx_ready !== 1'b1 && g < 100) begin
      g++;
      tick();
    end
    n_checks++;
    if (g != CS_IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_len: %0d cycles busy=%b, required %0d and busy 0", g, busy, CS_IDLE);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    logic s1, s2;
    d0 = done_cnt;
    send(8'h3C, 1'b0, 1'b1, s1);
    send(8'hFF, 1'b1, 1'b1, s2);
    n_checks++;
    if (s2 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept_phase: sclk=%b at accept, required 1", s2);
    end
    wait_done(d0);
    n_checks++;
    if (xfer_rises != 16 || max_gap != 2 * CLK_DIV) begin
      n_fail++;
      $display("FAIL b2b_rises: rises=%0d max_gap=%0d, required 16/%0d", xfer_rises, max_gap,
               2 * CLK_DIV);
    end
    n_checks++;
    if (low_len != CS_SETUP + 32 * CLK_DIV + CS_HOLD) begin
      n_fail++;
      $display("FAIL b2b_nss_low: %0d cycles, required %0d", low_len,
               CS_SETUP + 32 * CLK_DIV + CS_HOLD);
    end
    wait_idle();
  endtask

  task automatic test_wait;
    int d0, t;
    logic s;
    d0 = done_cnt;
    send(8'h81, 1'b0, 1'b1, s);
    t = 0;
    while (!(tx_ready === 1'b1 && sclk === 1'b0 && nss === 1'b0) && t < BOUND) begin
      tick();
      t++;
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({sclk, nss, tx_ready, mosi, busy} !== 5'b00111) begin
        n_fail++;
        $display("FAIL wait_state: cycle %0d sclk,nss,ready,mosi,busy=%b required 00111", i,
                 {sclk, nss, tx_ready, mosi, busy});
      end
      tick();
    end
    send(8'h7E, 1'b1, 1'b1, s);
    wait_done(d0);
    n_checks++;
    if (xfer_rises != 16) begin
      n_fail++;
      $display("FAIL wait_rises: %0d, required 16", xfer_rises);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid;
    int d0, ab0, b0, t;
    logic s;
    ab0 = abandoned;
    b0 = bytes_seen;
    send(8'hC3, 1'b1, 1'b0, s);
    t = 0;
    while (!(rises == 3 && nss === 1'b0) && t < BOUND) begin
      tick();
      t++;
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({nss, sclk, tx_ready, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midreset_state: nss,sclk,ready,busy=%b required 1000",
               {nss, sclk, tx_ready, busy});
    end
    n_checks++;
    if (abandoned != ab0 + 1 || bytes_seen != b0) begin
      n_fail++;
      $display("FAIL midreset_abandon: abandoned +%0d bytes +%0d, required +1/+0",
               abandoned - ab0, bytes_seen - b0);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_release: ready=%b required 1", tx_ready);
    end
    d0 = done_cnt;
    send(8'h55, 1'b1, 1'b1, s);
    wait_done(d0);
    n_checks++;
    if (xfer_rises != 8 || low_len != CS_SETUP + 16 * CLK_DIV + CS_HOLD) begin
      n_fail++;
      $display("FAIL after_reset_xfer: rises=%0d nss_low=%0d, required 8/%0d", xfer_rises,
               low_len, CS_SETUP + 16 * CLK_DIV + CS_HOLD);
    end
    wait_idle();
  endtask

  task automatic test_stream;
    int d0, b0;
    logic s;
    d0 = done_cnt;
    b0 = bytes_seen;
    send(8'h00, 1'b0, 1'b1, s);
    send(8'hFF, 1'b0, 1'b1, s);
    send(8'h5A, 1'b0, 1'b1, s);
    send(8'hA5, 1'b1, 1'b1, s);
    wait_done(d0);
    n_checks++;
    if (bytes_seen - b0 != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream: %0d bytes decoded, %0d pending, required 4/0", bytes_seen - b0,
               sb.size());
    end
    wait_idle();
  endtask

`ifdef SPI_M_MISO_EN
  task automatic test_miso;
    int d0, p0;
    logic s;
    d0 = done_cnt;
    p0 = rx_pulses;
    send(8'h96, 1'b1, 1'b1, s);
    wait_done(d0);
    repeat (4) tick();
    n_checks++;
    if (rx_pulses - p0 != 1 || rx_last !== 8'h96) begin
      n_fail++;
      $display("FAIL miso_loop: %0d pulses data=0x%02h, required 1/0x96", rx_pulses - p0,
               rx_last);
    end
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wait();
    test_reset_mid();
    test_stream();
`ifdef SPI_M_MISO_EN
    test_miso();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d bytes never seen, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
